// File: rtl/ariane_pkg.sv
// ariane_pkg: core-wide types and constants used by the FLU write-back arbiter.
//   TRANS_ID_BITS    - scoreboard transaction id width
//   FLU_WB_DEPTH     - default multiplier-result holding queue depth
//   FLU_STARVE_LIMIT - default max consecutive FLU grants over a waiting queue
//   flu_wb_entry_t   - queued multiplier result {result, trans_id}
//   wb_src_e         - write-port source selected in the current cycle
package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS    = 3;
    localparam int unsigned FLU_WB_DEPTH     = 2;
    localparam int unsigned FLU_STARVE_LIMIT = 4;

    typedef struct packed {
        logic [riscv::XLEN-1:0]   result;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } flu_wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FLU,
        SRC_QUEUE,
        SRC_MULT
    } wb_src_e;

endpackage

// File: rtl/riscv_pkg.sv
// riscv: ISA-level constants shared across the core.
//   XLEN - integer register / result width in bits.
package riscv;

    localparam int unsigned XLEN = 64;

endpackage

// File: rtl/flu_wb_queue.sv
// flu_wb_queue: circular buffer holding multiplier results that lost the
// write port. Push and pop may occur in the same cycle (count unchanged).
//   clk_i, rst_i   - clock, synchronous active-high reset (priority over flush)
//   flush_i        - empties the buffer at the clock edge
//   push_i, data_i - enqueue at tail
//   pop_i          - dequeue head
//   data_o         - current head entry (valid when !empty_o)
//   count_o        - occupancy, empty_o / full_o - occupancy flags
module flu_wb_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = FLU_WB_DEPTH
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             flush_i,
    input  logic                             push_i,
    input  flu_wb_entry_t                    data_i,
    input  logic                             pop_i,
    output flu_wb_entry_t                    data_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o,
    output logic                             empty_o,
    output logic                             full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    flu_wb_entry_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    assign data_o  = mem[rd_ptr_q];

    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= data_i;
                wr_ptr_q      <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/flu_wb_arbiter.sv
// flu_wb_arbiter: shares the scoreboard write port between the single-cycle
// FLU and the multiplier. Losing multiplier results wait in flu_wb_queue and
// drain in order; a starve counter bounds how long the FLU may hold them off.
//   clk_i, rst_i                                   - clock, sync active-high reset
//   flush_i                                        - pipeline flush
//   flu_valid_i / flu_result_i / flu_trans_id_i    - FLU result
//   mult_valid_i / mult_result_i / mult_trans_id_i - multiplier result
//   wb_valid_o / wb_result_o / wb_trans_id_o       - shared write port
//   flu_ready_o, mult_ready_o                      - issue permission
//   collision_cnt_o                                - only with FLU_WB_ARB_PERF_EN:
//                                                    saturating count of enqueued
//                                                    multiplier results
module flu_wb_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH        = FLU_WB_DEPTH,
    parameter int unsigned STARVE_LIMIT = FLU_STARVE_LIMIT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     flu_valid_i,
    input  logic [riscv::XLEN-1:0]   flu_result_i,
    input  logic [TRANS_ID_BITS-1:0] flu_trans_id_i,
    input  logic                     mult_valid_i,
    input  logic [riscv::XLEN-1:0]   mult_result_i,
    input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
    output logic                     wb_valid_o,
    output logic [riscv::XLEN-1:0]   wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic                     flu_ready_o,
    output logic                     mult_ready_o
`ifdef FLU_WB_ARB_PERF_EN
    ,
    output logic [31:0]              collision_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT+1);
    localparam logic [CNT_W-1:0] MREADY_MAX = CNT_W'(DEPTH-2);
    localparam logic [STV_W-1:0] STARVE_C   = STV_W'(STARVE_LIMIT);

    flu_wb_entry_t    q_head, q_in;
    logic [CNT_W-1:0] q_count;
    logic             q_empty, q_full;
    logic             q_push, q_pop;
    logic [STV_W-1:0] starve_q;
    logic             force_drain;
    wb_src_e          src;

    assign q_in.result   = mult_result_i;
    assign q_in.trans_id = mult_trans_id_i;

    flu_wb_queue #(
        .DEPTH (DEPTH)
    ) i_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (q_push),
        .data_i  (q_in),
        .pop_i   (q_pop),
        .data_o  (q_head),
        .count_o (q_count),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    // Both causes can only arise with a non-empty queue, so the head is always drainable.
    assign force_drain = q_full || (starve_q == STARVE_C);

    always_comb begin
        src = SRC_NONE;
        if (rst_i || flush_i) begin
            src = SRC_NONE;
        end else if (force_drain) begin
            src = SRC_QUEUE;
        end else if (flu_valid_i) begin
            src = SRC_FLU;
        end else if (!q_empty) begin
            src = SRC_QUEUE;
        end else if (mult_valid_i) begin
            src = SRC_MULT;
        end
    end

    assign q_pop  = (src == SRC_QUEUE);
    assign q_push = mult_valid_i && (src != SRC_MULT) && !flush_i && !rst_i;

    always_comb begin
        wb_valid_o    = 1'b0;
        wb_result_o   = '0;
        wb_trans_id_o = '0;
        case (src)
            SRC_FLU: begin
                wb_valid_o    = 1'b1;
                wb_result_o   = flu_result_i;
                wb_trans_id_o = flu_trans_id_i;
            end
            SRC_QUEUE: begin
                wb_valid_o    = 1'b1;
                wb_result_o   = q_head.result;
                wb_trans_id_o = q_head.trans_id;
            end
            SRC_MULT: begin
                wb_valid_o    = 1'b1;
                wb_result_o   = mult_result_i;
                wb_trans_id_o = mult_trans_id_i;
            end
            default: ;
        endcase
    end

    // One slot of headroom is kept for a multiplier result already in flight.
    assign mult_ready_o = rst_i || (q_count <= MREADY_MAX);
    assign flu_ready_o  = rst_i || !force_drain;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            starve_q <= '0;
        end else if (q_pop || q_empty) begin
            starve_q <= '0;
        end else if ((src == SRC_FLU) && (starve_q != STARVE_C)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

`ifdef FLU_WB_ARB_PERF_EN
    logic [31:0] collision_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            collision_cnt_q <= '0;
        end else if (q_push && (collision_cnt_q != '1)) begin
            collision_cnt_q <= collision_cnt_q + 32'd1;
        end
    end

    assign collision_cnt_o = collision_cnt_q;
`endif

`ifndef SYNTHESIS
    a_flu_issue_ok : assert property (@(posedge clk_i) disable iff (rst_i)
        flu_valid_i |-> flu_ready_o);
    a_mult_not_full : assert property (@(posedge clk_i) disable iff (rst_i)
        mult_valid_i |-> !q_full);
`endif

endmodule
